// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one ALU.
// Macro ALU_ARB_LOCK_EN adds req0_lock/req1_lock.
//
// Ports:
//   clk, rstn       clock, async active-low reset
//   reqN_*          request channel N (valid/ready, a, b, ctrl)
//   rspN_*          response channel N (valid/ready, data, zero, ovf)
//   alu_a/b/shamt/ctrl  drive to the shared ALU
//   alu_out/zero/ovf    combinational result from the shared ALU
//   reqN_lock       (ALU_ARB_LOCK_EN only) keep ownership after accept
//
// Data width comes from `XLEN (xgriscv_defines.v); falls back to 32.

`ifndef XLEN
`define XLEN 32
`endif

module alu_arbiter (
  input  logic             clk,
  input  logic             rstn,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [`XLEN-1:0] req0_a,
  input  logic [`XLEN-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [`XLEN-1:0] req1_a,
  input  logic [`XLEN-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,

`ifdef ALU_ARB_LOCK_EN
  input  logic             req0_lock,
  input  logic             req1_lock,
`endif

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [`XLEN-1:0] rsp0_data,
  output logic             rsp0_zero,
  output logic             rsp0_ovf,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [`XLEN-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic             rsp1_ovf,

  output logic [`XLEN-1:0] alu_a,
  output logic [`XLEN-1:0] alu_b,
  output logic [4:0]       alu_shamt,
  output logic [3:0]       alu_ctrl,

  input  logic [`XLEN-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_ovf
);

  localparam int XLEN = `XLEN;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic            lock_q, lock_d;
  logic            lock_own_q, lock_own_d;

  logic elig0, elig1;
  logic gnt0, gnt1;
  logic acc_lock;
  logic rsp_hs;

  // A held lock masks the other requester.
  assign elig0 = req0_valid & (~lock_q | ~lock_own_q);
  assign elig1 = req1_valid & (~lock_q | lock_own_q);

`ifdef ALU_ARB_LOCK_EN
  assign acc_lock = gnt1 ? req1_lock : req0_lock;
`else
  assign acc_lock = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        elig0 & elig1: begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end
        elig0 & ~elig1: gnt0 = 1'b1;
        ~elig0 & elig1: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_shamt = '0;
    alu_ctrl  = '0;
    unique case (1'b1)
      gnt0: begin
        alu_a     = req0_a;
        alu_b     = req0_b;
        alu_shamt = req0_b[4:0];
        alu_ctrl  = req0_ctrl;
      end
      gnt1: begin
        alu_a     = req1_a;
        alu_b     = req1_b;
        alu_shamt = req1_b[4:0];
        alu_ctrl  = req1_ctrl;
      end
      default: ;
    endcase
  end

  assign rsp_hs = (state_q == RESP) &
                  (owner_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    data_d     = data_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    if (gnt0 | gnt1) begin
      state_d    = RESP;
      owner_d    = gnt1;
      last_d     = gnt1;
      data_d     = alu_out;
      zero_d     = alu_zero;
      ovf_d      = alu_ovf;
      lock_d     = acc_lock;
      lock_own_d = gnt1;
    end else if (rsp_hs) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      data_q     <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      data_q     <= data_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) & owner_q;

  assign rsp0_data = rsp0_valid ? data_q : '0;
  assign rsp0_zero = rsp0_valid & zero_q;
  assign rsp0_ovf  = rsp0_valid & ovf_q;

  assign rsp1_data = rsp1_valid ? data_q : '0;
  assign rsp1_zero = rsp1_valid & zero_q;
  assign rsp1_ovf  = rsp1_valid & ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random + directed bench for alu_arbiter.
// Transaction-level reference model, behavioural shared ALU.

`ifndef XLEN
`define XLEN 32
`endif

module tb_alu_arbiter;

  localparam int XLEN = `XLEN;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;

  logic clk = 1'b0;
  logic rstn = 1'b1;

  logic            v  [2];
  logic [XLEN-1:0] a  [2];
  logic [XLEN-1:0] b  [2];
  logic [3:0]      c  [2];
  logic            rr [2];
`ifdef ALU_ARB_LOCK_EN
  logic            lk [2];
`endif

  logic            req0_ready, req1_ready;
  logic            rsp0_valid, rsp1_valid;
  logic [XLEN-1:0] rsp0_data, rsp1_data;
  logic            rsp0_zero, rsp1_zero;
  logic            rsp0_ovf, rsp1_ovf;
  logic [XLEN-1:0] alu_a, alu_b, alu_out;
  logic [4:0]      alu_shamt;
  logic [3:0]      alu_ctrl;
  logic            alu_zero, alu_ovf;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: one outstanding transaction at most
  bit              m_busy;
  int              m_own;
  int              m_last;
  int              m_lock;
  logic [XLEN-1:0] m_data;
  logic            m_z, m_o;
  int              last_g;
  int              grants[$];

  always #5 clk = ~clk;

  function automatic logic [XLEN+1:0] alu_ref(
    input logic [XLEN-1:0] x,
    input logic [XLEN-1:0] y,
    input logic [4:0]      sh,
    input logic [3:0]      op
  );
    logic [XLEN-1:0] r;
    logic o;
    o = 1'b0;
    case (op)
      OP_ADD: begin
        r = x + y;
        o = (x[XLEN-1] == y[XLEN-1]) && (r[XLEN-1] != x[XLEN-1]);
      end
      OP_SUB: begin
        r = x - y;
        o = (x[XLEN-1] != y[XLEN-1]) && (r[XLEN-1] != x[XLEN-1]);
      end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SLL: r = x << sh;
      default: r = '0;
    endcase
    return {o, (r == '0), r};
  endfunction

  always_comb
    {alu_ovf, alu_zero, alu_out} = alu_ref(alu_a, alu_b, alu_shamt, alu_ctrl);

  alu_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (v[0]),
    .req0_ready (req0_ready),
    .req0_a     (a[0]),
    .req0_b     (b[0]),
    .req0_ctrl  (c[0]),
    .req1_valid (v[1]),
    .req1_ready (req1_ready),
    .req1_a     (a[1]),
    .req1_b     (b[1]),
    .req1_ctrl  (c[1]),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock  (lk[0]),
    .req1_lock  (lk[1]),
`endif
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rr[0]),
    .rsp0_data  (rsp0_data),
    .rsp0_zero  (rsp0_zero),
    .rsp0_ovf   (rsp0_ovf),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rr[1]),
    .rsp1_data  (rsp1_data),
    .rsp1_zero  (rsp1_zero),
    .rsp1_ovf   (rsp1_ovf),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_shamt  (alu_shamt),
    .alu_ctrl   (alu_ctrl),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_ovf    (alu_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rnd_val();
    logic [XLEN-1:0] r;
    case ($urandom_range(5))
      0: r = '0;
      1: r = '1;
      2: r = {1'b0, {(XLEN-1){1'b1}}};
      3: r = {1'b1, {(XLEN-1){1'b0}}};
      4: r = XLEN'($urandom_range(15));
      default: r = XLEN'({$urandom, $urandom});
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_own  = 0;
    m_last = 1;
    m_lock = -1;
    m_data = '0;
    m_z    = 1'b0;
    m_o    = 1'b0;
    last_g = -1;
  endtask

  // Assert reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    v[0] = 1'b0;
    v[1] = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    lk[0] = 1'b0;
    lk[1] = 1'b0;
`endif
    rstn = 1'b0;
    #2;
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    chk("rst_zero_ovf", {rsp0_zero, rsp0_ovf, rsp1_zero, rsp1_ovf}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctl", {alu_shamt, alu_ctrl}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // One clock: check everything at negedge, then advance the model.
  task automatic step();
    int g;
    bit c0, c1, e0, e1;
    logic [XLEN-1:0] bg;
    logic [XLEN+1:0] r;
    @(negedge clk);
    g = -1;
    if (!m_busy) begin
      c0 = v[0] && (m_lock < 0 || m_lock == 0);
      c1 = v[1] && (m_lock < 0 || m_lock == 1);
      if (c0 && c1) g = 1 - m_last;
      else if (c0)  g = 0;
      else if (c1)  g = 1;
    end
    chk("ready0", req0_ready, g == 0);
    chk("ready1", req1_ready, g == 1);
    if (g >= 0) begin
      bg = b[g];
      chk("alu_a", alu_a, a[g]);
      chk("alu_b", alu_b, bg);
      chk("alu_shamt", alu_shamt, bg[4:0]);
      chk("alu_ctrl", alu_ctrl, c[g]);
    end else begin
      chk("alu_idle", {alu_a, alu_b, alu_shamt, alu_ctrl}, 0);
    end
    e0 = m_busy && m_own == 0;
    e1 = m_busy && m_own == 1;
    chk("rsp0_valid", rsp0_valid, e0);
    chk("rsp1_valid", rsp1_valid, e1);
    chk("rsp0_data", rsp0_data, e0 ? m_data : '0);
    chk("rsp1_data", rsp1_data, e1 ? m_data : '0);
    chk("rsp0_flags", {rsp0_zero, rsp0_ovf}, e0 ? {m_z, m_o} : 2'b00);
    chk("rsp1_flags", {rsp1_zero, rsp1_ovf}, e1 ? {m_z, m_o} : 2'b00);
    last_g = g;
    @(posedge clk);
    if (g >= 0) begin
      bg = b[g];
      r = alu_ref(a[g], bg, bg[4:0], c[g]);
      m_busy = 1'b1;
      m_own  = g;
      m_last = g;
      m_data = r[XLEN-1:0];
      m_z    = r[XLEN];
      m_o    = r[XLEN+1];
`ifdef ALU_ARB_LOCK_EN
      m_lock = lk[g] ? g : -1;
`endif
      grants.push_back(g);
    end else if (m_busy && rr[m_own]) begin
      m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic drive_random();
    for (int n = 0; n < 2; n++) begin
      if (last_g == n) v[n] = 1'b0;
      else if (v[n] && $urandom_range(15) == 0) v[n] = 1'b0;
      if (!v[n] && $urandom_range(2) == 0) begin
        v[n] = 1'b1;
        a[n] = rnd_val();
        b[n] = ($urandom_range(5) == 0) ? a[n] : rnd_val();
        c[n] = 4'($urandom_range(5));
`ifdef ALU_ARB_LOCK_EN
        lk[n] = ($urandom_range(3) == 0);
`endif
      end
      rr[n] = ($urandom_range(3) != 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      v[n]  = 1'b0;
      a[n]  = '0;
      b[n]  = '0;
      c[n]  = '0;
      rr[n] = 1'b1;
`ifdef ALU_ARB_LOCK_EN
      lk[n] = 1'b0;
`endif
    end
    model_reset();
    #1;

    // single ADD on channel 0
    do_reset();
    v[0] = 1'b1;
    a[0] = XLEN'(5);
    b[0] = XLEN'(7);
    c[0] = OP_ADD;
    step();
    v[0] = 1'b0;
    chk("t25_rsp0_valid", rsp0_valid, 1);
    chk("t25_data", rsp0_data, 12);
    chk("t25_zero", rsp0_zero, 0);
    chk("t25_rsp1_valid", rsp1_valid, 0);
    step();

    // both valid every cycle: strict alternation
    do_reset();
    grants.delete();
    v[0] = 1'b1;
    a[0] = rnd_val();
    b[0] = rnd_val();
    c[0] = OP_ADD;
    v[1] = 1'b1;
    a[1] = XLEN'(3);
    b[1] = XLEN'(3);
    c[1] = OP_SUB;
    for (int k = 0; k < 20 && grants.size() < 4; k++) begin
      step();
      if (last_g == 1) begin
        chk("t26_data1", rsp1_data, 0);
        chk("t26_zero1", rsp1_zero, 1);
      end
    end
    for (int i = 0; i < 4; i++)
      chk("t26_order", (i < grants.size()) ? grants[i] : -1, i % 2);

    // indefinite backpressure on an overflowing ADD
    do_reset();
    v[0] = 1'b1;
    a[0] = {1'b0, {(XLEN-1){1'b1}}};
    b[0] = XLEN'(1);
    c[0] = OP_ADD;
    v[1] = 1'b1;
    a[1] = rnd_val();
    b[1] = rnd_val();
    c[1] = OP_XOR;
    rr[0] = 1'b0;
    rr[1] = 1'b1;
    step();
    v[0] = 1'b0;
    repeat (5) begin
      step();
      chk("t27_valid", rsp0_valid, 1);
      chk("t27_data", rsp0_data, {1'b1, {(XLEN-1){1'b0}}});
      chk("t27_ovf", rsp0_ovf, 1);
      chk("t27_ready1", req1_ready, 0);
    end
    rr[0] = 1'b1;
    step();
    chk("t27_idle", rsp0_valid, 0);
    step();
    chk("t27_req1_acc", rsp1_valid, 1);
    v[1] = 1'b0;
    step();

    // reset in the middle of a response
    do_reset();
    v[0] = 1'b1;
    a[0] = rnd_val();
    b[0] = rnd_val();
    c[0] = OP_ADD;
    rr[0] = 1'b0;
    rr[1] = 1'b0;
    step();
    v[0] = 1'b0;
    step();
    chk("t28_busy", rsp0_valid, 1);
    do_reset();
    rr[0] = 1'b1;
    rr[1] = 1'b1;
    step();
    chk("t28_dropped", rsp0_valid, 0);
    v[0] = 1'b1;
    v[1] = 1'b1;
    step();
    chk("t28_first0", rsp0_valid, 1);
    chk("t28_not1", rsp1_valid, 0);
    step();

`ifdef ALU_ARB_LOCK_EN
    // lock held for three accepts, released on the fourth
    do_reset();
    grants.delete();
    v[0] = 1'b1;
    a[0] = rnd_val();
    b[0] = rnd_val();
    c[0] = OP_ADD;
    v[1] = 1'b1;
    a[1] = rnd_val();
    b[1] = rnd_val();
    c[1] = OP_ADD;
    rr[0] = 1'b1;
    rr[1] = 1'b1;
    for (int k = 0; k < 40 && grants.size() < 5; k++) begin
      lk[0] = (grants.size() < 3);
      step();
    end
    for (int i = 0; i < 5; i++)
      chk("t29_order", (i < grants.size()) ? grants[i] : -1,
          (i < 4) ? 0 : 1);
`endif

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step();
      drive_random();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
